// File: rtl/alu_md_unit.sv
// EX-stage ALU with built-in ALUop/funct decode and a radix-2 multiply/divide engine.
// The engine owns the HI/LO registers and uses a valid/ready handshake.
module alu_md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_XOR   = 6'd38;
    localparam logic [5:0] F_NOR   = 6'd39;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SLTU  = 6'd43;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lo_sh;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] a_saved;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             run_div;
    logic             run_dz;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] alu_res;
    logic             op_illegal;
    logic             is_md;
    logic             md_div;
    logic             md_signed;

    assign in_ready = (state == ST_IDLE);

    logic accept;
    assign accept = in_valid && in_ready;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        alu_res    = '0;
        op_illegal = 1'b0;
        is_md      = 1'b0;
        md_div     = 1'b0;
        md_signed  = 1'b0;
        case (ALUop)
            2'd0: alu_res = a + b;
            2'd1: alu_res = a - b;
            2'd2: begin
                case (funct)
                    F_ADD:   alu_res = a + b;
                    F_SUB:   alu_res = a - b;
                    F_AND:   alu_res = a & b;
                    F_OR:    alu_res = a | b;
                    F_XOR:   alu_res = a ^ b;
                    F_NOR:   alu_res = ~(a | b);
                    F_SLT:   alu_res = WIDTH'($signed(a) < $signed(b));
                    F_SLTU:  alu_res = WIDTH'(a < b);
                    F_MFHI:  alu_res = hi;
                    F_MFLO:  alu_res = lo;
                    F_MULT:  begin is_md = 1'b1; md_signed = 1'b1; end
                    F_MULTU: is_md = 1'b1;
                    F_DIV:   begin is_md = 1'b1; md_div = 1'b1; md_signed = 1'b1; end
                    F_DIVU:  begin is_md = 1'b1; md_div = 1'b1; end
                    default: op_illegal = 1'b1;
                endcase
            end
            default: op_illegal = 1'b1;
        endcase
    end

    // Signed operations run on magnitudes; signs are restored at completion.
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    assign a_neg = md_signed & a[WIDTH-1];
    assign b_neg = md_signed & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shifted;
    logic             no_borrow;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] lo_nx;

    // Multiply: {acc, lo_sh} shifts right, adding opnd when the multiplier LSB is set.
    // Divide:   {acc, lo_sh} shifts left, restoring when the trial subtract borrows.
    always_comb begin
        mul_sum   = {1'b0, acc} + (lo_sh[0] ? {1'b0, opnd} : '0);
        shifted   = {acc, lo_sh[WIDTH-1]};
        no_borrow = (shifted >= {1'b0, opnd});
        if (run_div) begin
            acc_nx = no_borrow ? WIDTH'(shifted - {1'b0, opnd}) : shifted[WIDTH-1:0];
            lo_nx  = {lo_sh[WIDTH-2:0], no_borrow};
        end else begin
            acc_nx = mul_sum[WIDTH:1];
            lo_nx  = {mul_sum[0], lo_sh[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    always_comb begin
        prod     = {acc, lo_sh};
        prod_fix = neg_q ? -prod : prod;
        if (!run_div) begin
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
            fin_lo = prod_fix[WIDTH-1:0];
        end else if (run_dz) begin
            fin_hi = a_saved;
            fin_lo = '1;
        end else begin
            fin_hi = neg_r ? -acc : acc;
            fin_lo = neg_q ? -lo_sh : lo_sh;
        end
    end

    // NOTE: HI/LO are ordinary registers, so the asynchronous reset clears them like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc       <= '0;
            lo_sh     <= '0;
            opnd      <= '0;
            a_saved   <= '0;
            hi        <= '0;
            lo        <= '0;
            run_div   <= 1'b0;
            run_dz    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && is_md) begin
                        state   <= ST_RUN;
                        cnt     <= '0;
                        acc     <= '0;
                        lo_sh   <= md_div ? a_mag : b_mag;
                        opnd    <= md_div ? b_mag : a_mag;
                        a_saved <= a;
                        run_div <= md_div;
                        run_dz  <= md_div && (b == '0);
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                    end else if (accept) begin
                        out_valid <= 1'b1;
                        result    <= alu_res;
                        zero      <= (alu_res == '0);
                        illegal   <= op_illegal;
                        div_zero  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_nx;
                    lo_sh <= lo_nx;
                    if (cnt == CNT_LAST) begin
                        state <= ST_FIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_FIN: begin
                    state     <= ST_IDLE;
                    hi        <= fin_hi;
                    lo        <= fin_lo;
                    out_valid <= 1'b1;
                    result    <= fin_lo;
                    zero      <= (fin_lo == '0);
                    illegal   <= 1'b0;
                    div_zero  <= run_dz;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_md_unit.sv
// Directed bench for alu_md_unit: WIDTH=32 instance for the main sequence, WIDTH=8 for multu.
module tb_alu_md_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ALUop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        div_zero;

    logic        in_valid8;
    logic        in_ready8;
    logic [1:0]  ALUop8;
    logic [5:0]  funct8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        out_valid8;
    logic [7:0]  result8;
    logic        zero8;
    logic        illegal8;
    logic        div_zero8;

    int checks = 0;
    int errors = 0;
    int n;
    int strobes;

    always #5 clk = ~clk;

    alu_md_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUop(ALUop), .funct(funct), .a(a), .b(b), .out_valid(out_valid),
        .result(result), .zero(zero), .illegal(illegal), .div_zero(div_zero)
    );

    alu_md_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .ALUop(ALUop8), .funct(funct8), .a(a8), .b(b8), .out_valid(out_valid8),
        .result(result8), .zero(zero8), .illegal(illegal8), .div_zero(div_zero8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; presents a request for exactly one accept edge.
    task automatic do_op(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1;
        ALUop    = op;
        funct    = f;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid, bounded.
    task automatic wait_strobe(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!out_valid && edges < 100);
    endtask

    task automatic md_check(input string tag, input logic [5:0] f, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] exp_lo,
                            input logic [31:0] exp_hi, input logic exp_dz);
        int edges;
        do_op(2'd2, f, x, y);
        check({tag, " busy"}, in_ready, 1'b0);
        wait_strobe(edges);
        check({tag, " latency"}, edges, 33);
        check({tag, " ready back"}, in_ready, 1'b1);
        check({tag, " lo"}, result, exp_lo);
        check({tag, " div_zero"}, div_zero, exp_dz);
        do_op(2'd2, 6'd16, 32'd0, 32'd0);
        check({tag, " hi"}, result, exp_hi);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; ALUop = 2'd0; funct = 6'd0; a = '0; b = '0;
        in_valid8 = 1'b0; ALUop8 = 2'd0; funct8 = 6'd0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset result", result, 32'h0);
        check("reset flags", {zero, illegal, div_zero}, 3'b000);

        do_op(2'd2, 6'd34, 32'd5, 32'd7);
        check("sub strobe", out_valid, 1'b1);
        check("sub result", result, 32'hFFFF_FFFE);
        check("sub zero", zero, 1'b0);
        @(posedge clk); #1;
        check("strobe one cycle", out_valid, 1'b0);
        check("result held", result, 32'hFFFF_FFFE);

        do_op(2'd2, 6'd42, 32'hFFFF_FFFF, 32'd1);
        check("slt", result, 32'd1);
        do_op(2'd2, 6'd43, 32'hFFFF_FFFF, 32'd1);
        check("sltu", result, 32'd0);
        check("sltu zero", zero, 1'b1);
        check("back-to-back strobe", out_valid, 1'b1);
        do_op(2'd0, 6'd0, 32'hFFFF_FFFF, 32'd1);
        check("add wrap", {zero, result}, {1'b1, 32'h0});
        do_op(2'd1, 6'd0, 32'd3, 32'd5);
        check("aluop sub", result, 32'hFFFF_FFFE);
        do_op(2'd2, 6'd39, 32'h0000_FFFF, 32'h00FF_0000);
        check("nor", result, 32'hFF00_0000);
        do_op(2'd2, 6'd38, 32'hFF00_FF00, 32'h0FF0_0FF0);
        check("xor", result, 32'hF0F0_F0F0);
        do_op(2'd2, 6'd36, 32'hFF00_FF00, 32'h0FF0_0FF0);
        check("and", result, 32'h0F00_0F00);

        md_check("mult -3*7", 6'd24, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
        do_op(2'd2, 6'd18, 32'd0, 32'd0);
        check("mflo", result, 32'hFFFF_FFEB);
        md_check("div -7/2", 6'd26, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        md_check("div 7/-2", 6'd26, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        md_check("divu min/max", 6'd27, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        md_check("div min/-1", 6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0);
        md_check("divu 9/0", 6'd27, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b1);
        check("div_zero cleared", div_zero, 1'b0);

        do_op(2'd3, 6'd32, 32'd4, 32'd4);
        check("illegal aluop", {illegal, zero, result}, {2'b11, 32'h0});
        do_op(2'd2, 6'd63, 32'd4, 32'd4);
        check("illegal funct", {illegal, result}, {1'b1, 32'h0});
        do_op(2'd2, 6'd16, 32'd0, 32'd0);
        check("hi unchanged", {illegal, result}, {1'b0, 32'd9});

        // Add request held across a running multu.
        do_op(2'd2, 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        in_valid = 1'b1; ALUop = 2'd0; funct = 6'd0; a = 32'd2; b = 32'd3;
        wait_strobe(n);
        check("held latency", n, 33);
        check("multu lo", result, 32'h0000_0001);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("held add strobe", out_valid, 1'b1);
        check("held add result", result, 32'd5);
        do_op(2'd2, 6'd16, 32'd0, 32'd0);
        check("multu hi", result, 32'hFFFF_FFFE);

        // Reset in the middle of a mult.
        do_op(2'd2, 6'd24, 32'hFFFF_FFFD, 32'd7);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort out_valid", out_valid, 1'b0);
        check("abort in_ready", in_ready, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) strobes++;
        end
        check("no strobe after abort", strobes, 0);
        do_op(2'd2, 6'd16, 32'd0, 32'd0);
        check("hi cleared", result, 32'h0);
        do_op(2'd2, 6'd18, 32'd0, 32'd0);
        check("lo cleared", result, 32'h0);

        // WIDTH=8 multu 255*255.
        in_valid8 = 1'b1; ALUop8 = 2'd2; funct8 = 6'd25; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("w8 busy", in_ready8, 1'b0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid8 && n < 100);
        check("w8 latency", n, 9);
        check("w8 lo", result8, 8'h01);
        in_valid8 = 1'b1; funct8 = 6'd16;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("w8 hi", result8, 8'hFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
